// File: rtl/reg_wb_pkg.sv
// Shared defaults and request type for the register-file write buffer.
package reg_wb_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 32;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_write_buffer_if.sv
// Producer, register-file and lookup signals of the write buffer.
interface reg_write_buffer_if
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, stall, q_addr,
    input  in_ready, we, wAddr, wData, q_hit, q_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, stall, q_addr,
    output in_ready, we, wAddr, wData, q_hit, q_data, count
  );

endinterface

// File: rtl/reg_wb_fifo.sv
// Circular request store; exposes every slot and its valid bit for the lookup.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic [AW-1:0] ent_addr_o [DEPTH],
  output logic [DW-1:0] ent_data_o [DEPTH],
  output logic [DEPTH-1:0] ent_vld_o
);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] off;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign head_addr_o = mem_addr[rd_ptr_q];
  assign head_data_o = mem_data[rd_ptr_q];
  assign ent_addr_o  = mem_addr;
  assign ent_data_o  = mem_data;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // Slot validity follows from its distance past the read pointer.
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_vld_o[i] = (CW'(off) < count_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_addr[wr_ptr_q] <= push_addr_i;
      mem_data[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// Write buffer in front of the register file: FIFO, registered write port, pending-write lookup.
module reg_write_buffer
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_write_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic          we_q, we_d;
  logic [AW-1:0] wAddr_q, wAddr_d;
  logic [DW-1:0] wData_q, wData_d;
  logic [PW-1:0] idx;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign push = bus.in_valid && !full;
  assign pop  = !empty && !bus.stall;

  reg_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_addr_i (bus.in_addr),
    .push_data_i (bus.in_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .rd_ptr_o    (rd_ptr),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data),
    .ent_vld_o   (ent_vld)
  );

  always_comb begin
    we_d    = pop;
    wAddr_d = wAddr_q;
    wData_d = wData_q;
    if (pop) begin
      wAddr_d = head_addr;
      wData_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wAddr_q <= '0;
      wData_q <= '0;
    end else begin
      we_q    <= we_d;
      wAddr_q <= wAddr_d;
      wData_q <= wData_d;
    end
  end

  // Walk oldest to newest so the youngest match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (we_q && (wAddr_q == bus.q_addr)) begin
      hit      = 1'b1;
      hit_data = wData_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (ent_vld[idx] && (ent_addr[idx] == bus.q_addr)) begin
        hit      = 1'b1;
        hit_data = ent_data[idx];
      end
    end
  end

  assign bus.in_ready = !full;
  assign bus.we       = we_q;
  assign bus.wAddr    = wAddr_q;
  assign bus.wData    = wData_q;
  assign bus.q_hit    = hit;
  assign bus.q_data   = hit_data;
  assign bus.count    = count;

endmodule

// File: doc/reg_write_buffer.md
# reg_write_buffer

Write-request buffer placed directly upstream of the 8×32 register file. Accepts register writes from the producing stage over a valid/ready handshake and holds them in a small FIFO. Drains one write per cycle into the register file's `we`/`wAddr`/`wData` port. Also provides a lookup port so readers can see buffered writes that have not yet landed in the register file.

## Interface

**Parameters**
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `AW`, 3: register address width.
- `DW`, 32: register data width.

**Ports**
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: write request present.
- `in_ready` out 1: buffer can accept a request; equals `count < DEPTH`.
- `in_addr` in AW: target register.
- `in_data` in DW: write data.
- `stall` in 1: hold draining. No write is issued while high.
- `we` out 1: register-file write enable. Registered.
- `wAddr` out AW: register-file write address. Registered.
- `wData` out DW: register-file write data. Registered.
- `q_addr` in AW: lookup address.
- `q_hit` out 1: a pending write to `q_addr` exists. Combinational.
- `q_data` out DW: data of the newest pending write to `q_addr`. Zero when `q_hit`=0.
- `count` out $clog2(DEPTH+1): number of occupied FIFO entries.

## Operation
- **Push:** `in_valid && in_ready` at a posedge stores {`in_addr`, `in_data`} at the tail and advances `wr_ptr`.
- **Pop:** at a posedge, if `count != 0` and `!stall`, the head entry moves to `wAddr`/`wData`, `we` goes to 1, and `rd_ptr` advances. Otherwise `we` goes to 0; `wAddr`/`wData` keep their values.
- **Push and pop on the same edge:** both happen. `count` is unchanged.
  - `in_ready` is computed from the pre-edge `count`. A full buffer therefore refuses input even while it is popping.
- **Push while `in_ready`=0:** ignored. No state changes.
- **Empty buffer:** a request pushed at edge N cannot be popped before edge N+1. There is no bypass.
- **Pointers:** each is log2(DEPTH) bits, increments modulo DEPTH, and wraps naturally.
- **Lookup:** candidates are the valid FIFO entries plus the output stage (when `we`=1).
  - Priority is youngest first: the newest FIFO entry, then older entries, then the output stage.
  - `q_data` is the data of the highest-priority match.
- **Duplicate addresses:** writes to the same address are all kept and issued in order. There is no merging.
- **Reset (asserted, any time):** `we`=0, `wAddr`=0, `wData`=0, `count`=0, both pointers at 0.
  - This makes `in_ready`=1 and `q_hit`=0, `q_data`=0.
  - Pending writes are discarded, including any write mid-drain.
  - Storage array contents are don't-care; entry valid bits are derived from the pointers and `count`.

## Timing
- **Latency:**
  - Request accepted at edge N.
  - `we` is high during cycle N+1 → N+2.
  - The register file commits at edge N+2.
  - Minimum two edges from acceptance to commit.
- **Throughput:** one write per cycle sustained, with `stall`=0 and the buffer never full.
- **`stall` is sampled at the pop edge.** A `we` pulse already on the outputs is not retracted. `stall` only suppresses the next issue.
- **Combinational paths:**
  - `q_hit`/`q_data` depend on `q_addr` and current state.
  - `in_ready` depends on `count` only.
  - There are no combinational input-to-`in_ready` paths.
- **Reset release:** `reset_n` deasserts asynchronously. The first push can occur at the first posedge after release.

## Structure
- **Package `reg_wb_pkg`:**
  - Defaults `AW_DEF`=3 and `DW_DEF`=32.
  - Typedef `wr_req_t` {addr, data}.
- **Sub-module `reg_wb_fifo`:** storage array, pointers and `count`, with push/pop/full/empty.
  - Also exposes all entries and their valid bits to the parent for the lookup.
- **Top-level `reg_write_buffer`:** output stage registers and the lookup priority mux.

## Test plan
1. **Reset and single write.** Reset asserted at t=0, released at 7 ns. Push {1, 0x00000001}.
   - While in reset: `we`=0, `count`=0, `in_ready`=1.
   - `we`=1 with `wAddr`=1, `wData`=1 one cycle after acceptance, for exactly one cycle.
2. **Streaming.** Push addresses 1..7 with data 1..7 back-to-back, `stall`=0.
   - `we` stays high 7 consecutive cycles, carrying addresses 1..7 in order.
   - `count` never exceeds 1.
3. **Fill and refuse.** `stall`=1, push 5 requests.
   - After 4 accepted: `in_ready`=0 and `count`=4. The 5th is not stored.
   - Release `stall`: 4 writes issue in order and `in_ready` returns to 1 after the first pop.
4. **Lookup priority.** `stall`=1, push {3, 0xA}, {5, 0xB}, {3, 0xC}.
   - `q_addr`=3 gives `q_hit`=1, `q_data`=0xC.
   - `q_addr`=4 gives `q_hit`=0, `q_data`=0.
5. **Wrap-around.** 10 pushes interleaved with pops, `count` between 1 and 3.
   - Output order equals input order across pointer wrap. No loss or duplication.
6. **Reset mid-operation.** 3 entries pending and `we`=1; assert `reset_n`=0 between edges.
   - `we`=0 and `count`=0 immediately.
   - No further writes after release.
